// File: rtl/cpu_display_pkg.sv
// cpu_display_pkg: select codes and hex glyph table for the front-panel display
package cpu_display_pkg;
  typedef logic [2:0] sel_t;
  localparam sel_t SEL_RAM       = 3'd0;
  localparam sel_t SEL_CYCLES    = 3'd1;
  localparam sel_t SEL_CONDI     = 3'd2;
  localparam sel_t SEL_UNCONDI   = 3'd3;
  localparam sel_t SEL_CONDI_SUC = 3'd4;
  localparam sel_t SEL_SYSCALL   = 3'd5;
  localparam sel_t SEL_PC        = 3'd6;
  // active-high gfedcba patterns for hex digits 0..F
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [6:0] seg7(input logic [3:0] n);
    return SEG7_LUT[n];
  endfunction
endpackage

// File: rtl/seg_display_select_if.sv
// seg_display_select_if: debug words and select code in, digit/segment drives out
interface seg_display_select_if;
  import cpu_display_pkg::*;
  sel_t        display;
  logic [31:0] ram_display;
  logic [31:0] total_cycles;
  logic [31:0] condi_num;
  logic [31:0] uncondi_num;
  logic [31:0] condi_suc_num;
  logic [31:0] syscall_out;
  logic [31:0] show_pc;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  modport master (
    output display, ram_display, total_cycles, condi_num, uncondi_num,
           condi_suc_num, syscall_out, show_pc,
    input  AN, SEG
  );
  modport slave (
    input  display, ram_display, total_cycles, condi_num, uncondi_num,
           condi_suc_num, syscall_out, show_pc,
    output AN, SEG
  );
endinterface

// File: rtl/seg_display_select_hex_to_seg7.sv
// hex_to_seg7: nibble to active-high gfedcba segment pattern
module hex_to_seg7
  import cpu_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  assign o_seg = seg7(i_nibble);
endmodule

// File: rtl/seg_display_select.sv
// seg_display_select: picks a debug word and scans it as 8 hex digits onto the display
module seg_display_select
  import cpu_display_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input logic clk,
  input logic rst,
  seg_display_select_if.slave bus
);
  localparam int W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [W-1:0] DIV_MAX = W'(SCAN_DIV - 1);
  logic [W-1:0] r_div_cnt;
  logic [2:0]   r_digit_idx;
  logic [7:0]   r_an;
  logic [7:0]   r_seg;
  logic [31:0]  w_sel_word;
  logic [3:0]   w_nibble;
  logic [6:0]   w_seg;
  logic         w_wrap;
  always_comb begin
    w_sel_word = '0;
    case (bus.display)
      SEL_RAM:       w_sel_word = bus.ram_display;
      SEL_CYCLES:    w_sel_word = bus.total_cycles;
      SEL_CONDI:     w_sel_word = bus.condi_num;
      SEL_UNCONDI:   w_sel_word = bus.uncondi_num;
      SEL_CONDI_SUC: w_sel_word = bus.condi_suc_num;
      SEL_SYSCALL:   w_sel_word = bus.syscall_out;
      SEL_PC:        w_sel_word = bus.show_pc;
      default:       w_sel_word = '0;
    endcase
  end
  assign w_nibble = w_sel_word[{r_digit_idx, 2'b00} +: 4];
  assign w_wrap   = r_div_cnt == DIV_MAX;
  hex_to_seg7 u_hex (.i_nibble(w_nibble), .o_seg(w_seg));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt   <= '0;
      r_digit_idx <= '0;
      r_an        <= '1;
      r_seg       <= '1;
    end else begin
      r_div_cnt   <= w_wrap ? '0 : r_div_cnt + 1'b1;
      r_digit_idx <= w_wrap ? r_digit_idx + 3'd1 : r_digit_idx;
      r_an        <= ~(8'b1 << r_digit_idx);
      r_seg       <= ~{1'b0, w_seg};
    end
  end
  assign bus.AN  = r_an;
  assign bus.SEG = r_seg;
endmodule

// File: tb/tb_seg_display_select.sv
// tb_seg_display_select: directed checks of select, scan timing, glyphs and reset
module tb_seg_display_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  seg_display_select_if bus ();
  seg_display_select_if bus1 ();
  seg_display_select #(.SCAN_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  seg_display_select #(.SCAN_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic restart(input logic [2:0] sel);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.display = sel;
  endtask
  logic [7:0] scan_seg [8];
  logic [7:0] glyph_seg [8];
  logic [7:0] sel_seg [7];
  initial begin
    scan_seg  = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
    glyph_seg = '{8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    sel_seg   = '{8'h80, 8'hF8, 8'hF9, 8'hA4, 8'hB0, 8'h92, 8'hC6};
    bus.display       = 3'd1;
    bus.ram_display   = 32'hFEDC_BA98;
    bus.total_cycles  = 32'h0123_4567;
    bus.condi_num     = 32'h0000_0011;
    bus.uncondi_num   = 32'h0000_0022;
    bus.condi_suc_num = 32'h0000_0033;
    bus.syscall_out   = 32'h0000_0055;
    bus.show_pc       = 32'h0000_0ABC;
    bus1.display       = 3'd7;
    bus1.ram_display   = '0;
    bus1.total_cycles  = '0;
    bus1.condi_num     = '0;
    bus1.uncondi_num   = '0;
    bus1.condi_suc_num = '0;
    bus1.syscall_out   = '0;
    bus1.show_pc       = '0;
    repeat (3) tick();
    chk("reset_an", bus.AN, 8'hFF);
    chk("reset_seg", bus.SEG, 8'hFF);
    rst = 1'b0;
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("scan_an_d%0d_c%0d", d, c), bus.AN, ~(8'b1 << d));
        chk($sformatf("scan_seg_d%0d_c%0d", d, c), bus.SEG, scan_seg[d]);
        chk($sformatf("div1_an_n%0d", d * 4 + c), bus1.AN, ~(8'b1 << ((d * 4 + c) % 8)));
        chk($sformatf("div1_seg_n%0d", d * 4 + c), bus1.SEG, 8'hC0);
      end
    tick();
    chk("scan_wrap_an", bus.AN, 8'hFE);
    for (int s = 0; s < 7; s++) begin
      restart(3'(s));
      tick();
      chk($sformatf("sel%0d_an", s), bus.AN, 8'hFE);
      chk($sformatf("sel%0d_seg", s), bus.SEG, sel_seg[s]);
    end
    restart(3'd7);
    for (int d = 0; d < 8; d++) begin
      tick();
      chk($sformatf("sel7_an_d%0d", d), bus.AN, ~(8'b1 << d));
      chk($sformatf("sel7_seg_d%0d", d), bus.SEG, 8'hC0);
      repeat (3) tick();
    end
    restart(3'd0);
    for (int d = 0; d < 8; d++)
      for (int c = 0; c < 4; c++) begin
        tick();
        chk($sformatf("glyph_seg_d%0d_c%0d", d, c), bus.SEG, glyph_seg[d]);
      end
    bus.show_pc = 32'h1234_9ABC;
    restart(3'd1);
    repeat (13) tick();
    chk("mid_pre_an", bus.AN, 8'hF7);
    chk("mid_pre_seg", bus.SEG, 8'h99);
    bus.display = 3'd6;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mid_an_c%0d", c), bus.AN, 8'hF7);
      chk($sformatf("mid_seg_c%0d", c), bus.SEG, 8'h90);
    end
    tick();
    chk("mid_next_an", bus.AN, 8'hEF);
    chk("mid_next_seg", bus.SEG, 8'h99);
    repeat (4) tick();
    chk("rst5_pre_an", bus.AN, 8'hDF);
    rst = 1'b1;
    tick();
    chk("rst5_an", bus.AN, 8'hFF);
    chk("rst5_seg", bus.SEG, 8'hFF);
    rst = 1'b0;
    tick();
    chk("rst5_rel_an", bus.AN, 8'hFE);
    chk("rst5_rel_seg", bus.SEG, 8'hC6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_display_select.md
Name: seg_display_select

Overview:
- Front-panel display driver for the pipelined CPU board.
- Selects one of seven 32-bit debug words (RAM word, statistics counters, syscall output, PC) using a 3-bit switch code.
- Time-multiplexes the selected word as 8 hex digits onto a common-anode 8-digit seven-segment display.
- Runs on the undivided board clock, independent of the CPU's divided clock.

Parameters:
- SCAN_DIV, 100000: board clock cycles per digit slot. Must be at least 1. With a 100 MHz clock this gives 1 kHz per digit.

Ports:
- clk  in  1  board clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- display  in  3  source select code.
- ram_display  in  32  data-memory word at the display address.
- total_cycles  in  32  total cycle count.
- condi_num  in  32  conditional branch count.
- uncondi_num  in  32  unconditional jump count.
- condi_suc_num  in  32  taken conditional branch count.
- syscall_out  in  32  syscall output register.
- show_pc  in  32  zero-extended PC.
- AN  out  8  digit enables, active-low, one-hot-zero.
- SEG  out  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Select decode, combinational, sampled live every cycle:
  - 000 ram_display; 001 total_cycles; 010 condi_num; 011 uncondi_num.
  - 100 condi_suc_num; 101 syscall_out; 110 show_pc; 111 constant 32'h0000_0000.
- Scan divider:
  - div_cnt counts 0..SCAN_DIV-1.
  - When div_cnt == SCAN_DIV-1 it wraps to 0, and digit_idx (3 bits) increments modulo 8 (7 -> 0).
- Digit mapping: digit_idx k shows nibble sel_word[4k+3:4k]. Digit 0 is the rightmost display position (bits 3:0); digit 7 is leftmost (bits 31:28).
- AN and SEG are registered: AN <= ~(8'b1 << digit_idx); SEG <= ~{1'b0, seg7(nibble)}. Decimal point is always off (SEG[7] = 1).
- Latency: a change on display, a data input, or digit_idx appears on AN/SEG on the next rising edge.
- seg7 mapping (gfedcba, active-high before inversion):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Resulting SEG examples: 0 -> C0, 8 -> 80, F -> 8E.
- Reset (rst high at a rising edge):
  - div_cnt = 0, digit_idx = 0, AN = 8'hFF (all digits dark), SEG = 8'hFF.
  - The first edge with rst low drives digit 0.
- Reset mid-scan: blanks the display immediately on that edge and restarts at digit 0 with div_cnt 0.
- Select change mid-scan:
  - Does not reset digit_idx or div_cnt.
  - The current digit shows the new word's corresponding nibble from the next edge.
- SCAN_DIV = 1: digit_idx advances every cycle.
- No other state; no handshake.

Decomposition:
- Shared package (cpu_display_pkg):
  - select code constants SEL_RAM=3'd0 .. SEL_PC=3'd6.
  - 7-bit segment pattern constants / function for the 16 hex glyphs.
  - typedef for the 3-bit select code.
- One sub-module: hex_to_seg7 (4-bit nibble in, 7-bit active-high gfedcba out, combinational).
- Select mux and scan counter stay in seg_display_select.

Test Plan (SCAN_DIV=4):
- Reset: hold rst 3 cycles -> AN=FF, SEG=FF. Release -> after 1 edge AN=FE, SEG for nibble 0 of selected word.
- Full scan:
  - Stimulus: display=001, total_cycles=32'h0123_4567.
  - Expected: over 32 cycles AN steps FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, with SEG = F8,82,92,99,B0,A4,F9,C0 (digits 7,6,5,4,3,2,1,0).
  - AN then wraps to FE.
- Select coverage:
  - Set each data input to a distinct pattern, e.g. show_pc=32'h0000_0ABC; step display 000..110.
  - Expected: digit 0 shows that source's low nibble (show_pc: C -> SEG=C6).
  - display=111 -> every digit SEG=C0.
- Hex glyphs: ram_display=32'hFEDC_BA98, display=000 -> digits 0..7 SEG = 80,90,88,83,C6,A1,86,8E.
- Mid-scan select change:
  - Switch display 001->110 while digit_idx=3.
  - Expected: next edge SEG reflects show_pc[15:12]; AN stays F7 until the slot ends (no counter restart).
- Mid-scan reset: assert rst while digit_idx=5 -> next edge AN=FF, SEG=FF. Release -> AN=FE.
